// File: rtl/pipe_boundary.sv
// pipe_boundary: elastic valid/ready pipeline-boundary register with flush, optional skid entry and debug counters
//   clk, rst                 : clock, synchronous active-high reset
//   i_valid, i_data, o_ready : upstream handshake (o_ready registered when SKID=1)
//   o_valid, o_data, i_ready : downstream handshake (o_data = NOP_VALUE when idle)
//   flush                    : squash held and incoming bundles
//   stall_cnt, bubble_cnt, flush_cnt : saturating debug counters
//   err                      : sticky invariant-violation flag (skid valid while main invalid)
module pipe_boundary #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] NOP_VALUE = 16'h0800,
    parameter bit               SKID      = 1'b1,
    parameter int               CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic [WIDTH-1:0]     i_data,
    output logic                 o_ready,
    output logic                 o_valid,
    output logic [WIDTH-1:0]     o_data,
    input  logic                 i_ready,
    input  logic                 flush,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] bubble_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt,
    output logic                 err
);
    logic                 main_v_q, main_v_d, skid_v_q, skid_v_d, err_q, err_d;
    logic [WIDTH-1:0]     main_d_q, main_d_d, skid_d_q, skid_d_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d, flush_cnt_q, flush_cnt_d;
    logic                 accept, drain;

    assign o_ready    = !flush && (SKID ? !skid_v_q : (!main_v_q || i_ready));
    assign o_valid    = main_v_q;
    assign o_data     = main_v_q ? main_d_q : NOP_VALUE;
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign err        = err_q;
    assign accept     = i_valid && o_ready;
    assign drain      = main_v_q && i_ready;

    always_comb begin
        main_v_d = main_v_q;
        main_d_d = main_d_q;
        skid_v_d = skid_v_q;
        skid_d_d = skid_d_q;
        if (SKID) begin
            // o_ready is low while skid is full, so a refill from skid never races an accept
            if (drain && skid_v_q) begin
                main_v_d = 1'b1;
                main_d_d = skid_d_q;
                skid_v_d = 1'b0;
            end else if (drain || !main_v_q) begin
                main_v_d = accept || (main_v_q && !drain);
                main_d_d = accept ? i_data : main_d_q;
            end else if (accept) begin
                skid_v_d = 1'b1;
                skid_d_d = i_data;
            end
        end else begin
            main_v_d = accept || (main_v_q && !drain);
            main_d_d = accept ? i_data : main_d_q;
            skid_v_d = 1'b0;
        end
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end
        stall_cnt_d  = (main_v_q && !i_ready && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        bubble_cnt_d = (!main_v_q && !(&bubble_cnt_q)) ? bubble_cnt_q + 1'b1 : bubble_cnt_q;
        flush_cnt_d  = (flush && (main_v_q || skid_v_q) && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
        err_d        = err_q || (skid_v_q && !main_v_q);
    end

    always_ff @(posedge clk) begin
        main_d_q <= main_d_d;
        skid_d_q <= skid_d_d;
        if (rst) begin
            main_v_q     <= 1'b0;
            skid_v_q     <= 1'b0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            main_v_q     <= main_v_d;
            skid_v_q     <= skid_v_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            err_q        <= err_d;
        end
    end
endmodule

// File: tb/tb_pipe_boundary.sv
// tb_pipe_boundary: directed checks of pipe_boundary in skid, non-skid and narrow-counter builds
module tb_pipe_boundary;
    logic        clk = 1'b0, rst = 1'b1, i_valid = 1'b0, i_ready = 1'b0, flush = 1'b0;
    logic [15:0] i_data = '0;
    logic        o_ready, o_valid, err, o_ready_z, o_valid_z, err_z, o_ready_s, o_valid_s, err_s;
    logic [15:0] o_data, stall_cnt, bubble_cnt, flush_cnt, o_data_z, stall_cnt_z, bubble_cnt_z, flush_cnt_z, o_data_s;
    logic [3:0]  stall_cnt_s, bubble_cnt_s, flush_cnt_s;
    int checks = 0, failures = 0;
    logic [15:0] snap;

    always #5 clk = ~clk;

    pipe_boundary #(.SKID(1'b1)) dut (.clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
        .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready), .flush(flush), .stall_cnt(stall_cnt),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt), .err(err));
    pipe_boundary #(.SKID(1'b0)) dut_z (.clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready_z),
        .o_valid(o_valid_z), .o_data(o_data_z), .i_ready(i_ready), .flush(flush), .stall_cnt(stall_cnt_z),
        .bubble_cnt(bubble_cnt_z), .flush_cnt(flush_cnt_z), .err(err_z));
    pipe_boundary #(.SKID(1'b1), .CNT_WIDTH(4)) dut_s (.clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
        .o_ready(o_ready_s), .o_valid(o_valid_s), .o_data(o_data_s), .i_ready(i_ready), .flush(flush),
        .stall_cnt(stall_cnt_s), .bubble_cnt(bubble_cnt_s), .flush_cnt(flush_cnt_s), .err(err_s));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; i_valid = 1'b1; i_data = 16'h1234; i_ready = 1'b0; flush = 1'b0;
        step(); step();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%h exp=0", o_valid); end
        checks++; if (o_data !== 16'h0800) begin failures++; $display("FAIL reset_o_data got=%h exp=0800", o_data); end
        checks++; if ({stall_cnt, bubble_cnt, flush_cnt} !== 48'h0) begin failures++; $display("FAIL reset_counters got=%h %h %h exp=0", stall_cnt, bubble_cnt, flush_cnt); end
        checks++; if (o_data_z !== 16'h0800 || o_valid_z !== 1'b0) begin failures++; $display("FAIL reset_noskid got=%h/%b exp=0800/0", o_data_z, o_valid_z); end
        rst = 1'b0; i_valid = 1'b0;
        #1;
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_o_ready got=%b exp=1", o_ready); end
        checks++; if (o_ready_z !== 1'b1) begin failures++; $display("FAIL reset_o_ready_noskid got=%b exp=1", o_ready_z); end
    endtask

    task automatic test_streaming;
        snap = stall_cnt;
        i_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            i_valid = 1'b1; i_data = 16'(k);
            step();
            checks++; if (o_valid !== 1'b1 || o_data !== 16'(k)) begin failures++; $display("FAIL stream_%0d got=%b/%h exp=1/%h", k, o_valid, o_data, 16'(k)); end
        end
        i_valid = 1'b0;
        step();
        checks++; if (o_valid !== 1'b0 || o_data !== 16'h0800) begin failures++; $display("FAIL stream_drained got=%b/%h exp=0/0800", o_valid, o_data); end
        checks++; if (stall_cnt !== snap) begin failures++; $display("FAIL stream_stall_cnt got=%h exp=%h", stall_cnt, snap); end
    endtask

    task automatic test_backpressure;
        i_ready = 1'b0; i_valid = 1'b1; i_data = 16'hA000;
        step();
        snap = stall_cnt;
        i_data = 16'hA001;
        checks++; if (o_ready !== 1'b1 || o_data !== 16'hA000) begin failures++; $display("FAIL bp_main got=%b/%h exp=1/a000", o_ready, o_data); end
        step();
        i_valid = 1'b0;
        checks++; if (o_ready !== 1'b0 || o_data !== 16'hA000) begin failures++; $display("FAIL bp_skid_full got=%b/%h exp=0/a000", o_ready, o_data); end
        step();
        checks++; if (o_data !== 16'hA000) begin failures++; $display("FAIL bp_hold got=%h exp=a000", o_data); end
        i_ready = 1'b1;
        checks++; if (stall_cnt !== snap + 16'd2) begin failures++; $display("FAIL bp_stall_cnt got=%h exp=%h", stall_cnt, snap + 16'd2); end
        step();
        checks++; if (o_valid !== 1'b1 || o_data !== 16'hA001 || o_ready !== 1'b1) begin failures++; $display("FAIL bp_second got=%b/%h/%b exp=1/a001/1", o_valid, o_data, o_ready); end
        step();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", o_valid); end
        checks++; if (stall_cnt !== snap + 16'd2) begin failures++; $display("FAIL bp_stall_final got=%h exp=%h", stall_cnt, snap + 16'd2); end
    endtask

    task automatic test_flush_race;
        i_ready = 1'b0; i_valid = 1'b1; i_data = 16'hB000;
        step();
        i_data = 16'hB001;
        step();
        snap = flush_cnt;
        i_data = 16'hB002; flush = 1'b1;
        #1;
        checks++; if (o_ready !== 1'b0 || o_ready_z !== 1'b0) begin failures++; $display("FAIL flush_o_ready got=%b/%b exp=0/0", o_ready, o_ready_z); end
        step();
        flush = 1'b0; i_valid = 1'b0;
        checks++; if (o_valid !== 1'b0 || o_data !== 16'h0800) begin failures++; $display("FAIL flush_out got=%b/%h exp=0/0800", o_valid, o_data); end
        checks++; if (flush_cnt !== snap + 16'd1) begin failures++; $display("FAIL flush_cnt got=%h exp=%h", flush_cnt, snap + 16'd1); end
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (o_valid !== 1'b0 || o_data === 16'hB002) begin failures++; $display("FAIL flush_leak_%0d got=%b/%h exp=0/0800", k, o_valid, o_data); end
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (flush_cnt !== snap + 16'd1) begin failures++; $display("FAIL flush_idle_cnt got=%h exp=%h", flush_cnt, snap + 16'd1); end
    endtask

    task automatic test_noskid;
        i_ready = 1'b0; i_valid = 1'b1; i_data = 16'hC000;
        step();
        checks++; if (o_valid_z !== 1'b1 || o_data_z !== 16'hC000) begin failures++; $display("FAIL noskid_hold got=%b/%h exp=1/c000", o_valid_z, o_data_z); end
        i_data = 16'hC001;
        #1;
        checks++; if (o_ready_z !== 1'b0) begin failures++; $display("FAIL noskid_ready_low got=%b exp=0", o_ready_z); end
        i_ready = 1'b1;
        #1;
        checks++; if (o_ready_z !== 1'b1) begin failures++; $display("FAIL noskid_ready_high got=%b exp=1", o_ready_z); end
        step();
        i_valid = 1'b0;
        checks++; if (o_valid_z !== 1'b1 || o_data_z !== 16'hC001) begin failures++; $display("FAIL noskid_pass got=%b/%h exp=1/c001", o_valid_z, o_data_z); end
        step();
        checks++; if (o_valid_z !== 1'b0 || o_data_z !== 16'h0800) begin failures++; $display("FAIL noskid_empty got=%b/%h exp=0/0800", o_valid_z, o_data_z); end
    endtask

    task automatic test_saturation;
        i_valid = 1'b0; i_ready = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bubble_cnt_s !== 4'h0) begin failures++; $display("FAIL sat_start got=%h exp=0", bubble_cnt_s); end
        for (int n = 1; n <= 20; n++) begin
            step();
            checks++; if (bubble_cnt_s !== ((n > 15) ? 4'hF : 4'(n))) begin failures++; $display("FAIL sat_%0d got=%h exp=%h", n, bubble_cnt_s, (n > 15) ? 4'hF : 4'(n)); end
        end
        checks++; if (bubble_cnt !== 16'd20) begin failures++; $display("FAIL sat_wide got=%h exp=0014", bubble_cnt); end
        checks++; if ({err, err_z, err_s} !== 3'b000) begin failures++; $display("FAIL err_flags got=%b exp=000", {err, err_z, err_s}); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_race();
        test_noskid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_boundary.md
Name: pipe_boundary

Overview:
- Parametrised elastic pipeline-boundary register that replaces the per-boundary fixed flops (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block.
- Carries a WIDTH-bit packed stage bundle with valid/ready handshakes on both sides.
- Provides flush (bubble insertion) for branch-mispredict squash.
- Optional skid entry so upstream ready is registered; stall/bubble/flush performance counters for debug.

Parameters:
- WIDTH, 16, width of the packed stage bundle.
- NOP_VALUE, 16'h0800, value driven on o_data whenever o_valid=0; must be WIDTH bits.
- SKID, 1, 1 = two-entry skid buffer with registered o_ready; 0 = single register with combinational o_ready.
- CNT_WIDTH, 16, width of each saturating performance counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- i_valid  input  1  upstream stage presents a valid bundle.
- i_data  input  WIDTH  upstream bundle.
- o_ready  output  1  boundary can accept i_data this cycle.
- o_valid  output  1  downstream bundle valid.
- o_data  output  WIDTH  downstream bundle; NOP_VALUE when o_valid=0.
- i_ready  input  1  downstream stage consumes o_data this cycle.
- flush  input  1  squash all held and incoming bundles.
- stall_cnt  output  CNT_WIDTH  cycles with o_valid=1 and i_ready=0.
- bubble_cnt  output  CNT_WIDTH  cycles with o_valid=0.
- flush_cnt  output  CNT_WIDTH  cycles with flush=1 while at least one entry was valid.
- err  output  1  sticky; set on an internal invariant violation (skid valid while main invalid).

Behaviour:
- State: main_v/main_d and, if SKID=1, skid_v/skid_d.
- Outputs: o_valid = main_v; o_data = main_v ? main_d : NOP_VALUE.
- Transfers: accept = i_valid & o_ready; drain = main_v & i_ready.
- Reset (rst=1 at edge): main_v=0, skid_v=0, all counters=0, err=0. The cycle after reset, o_valid=0, o_data=NOP_VALUE, and o_ready=1.
- flush=1:
  - o_ready forced 0 combinationally, so no upstream transfer completes.
  - At the edge, main_v=0 and skid_v=0. Flush wins over every simultaneous accept or drain.
  - Data registers may hold stale values; o_data still shows NOP_VALUE.
- SKID=1 (o_ready = !skid_v, a registered value):
  - drain & skid_v: main <= skid, skid_v <= 0. Accept is impossible here because o_ready=0.
  - drain & !skid_v: main_v <= accept; main_d <= i_data if accept.
  - !drain & main_v & accept: skid <= i_data, skid_v <= 1. Main holds.
  - !drain & !main_v & accept: main <= i_data.
  - Otherwise hold.
  - Latency: 1 cycle from accept to o_valid when empty. Full throughput at i_ready=1. Ordering is strictly preserved.
- SKID=0 (o_ready = !main_v | i_ready):
  - main_v <= accept | (main_v & !drain).
  - main_d <= i_data on accept.
- Counters:
  - Increment at the edge on their condition, evaluated on the pre-edge state.
  - Saturate at all-ones; no wrap.
  - Not affected by flush, except flush_cnt.
  - Frozen during rst.
- err: set at the edge if skid_v=1 and main_v=0. Cleared only by rst.
- Reset mid-transfer: in-flight bundles are discarded with no partial output. rst has priority over flush.

Test Plan:
- Reset: rst=1 for 2 cycles with i_valid=1 and i_data=16'h1234 -> o_valid=0, o_data=16'h0800, all counters 0; first post-reset cycle o_ready=1.
- Streaming (SKID=1): i_ready=1; push 16'h0001..16'h0008 on consecutive cycles -> o_data shows the same sequence, each one cycle later with no gaps; stall_cnt=0.
- Backpressure (SKID=1): main holds 16'hA000, i_ready=0, push 16'hA001 -> skid fills and o_ready=0 next cycle. Raise i_ready -> 16'hA000 then 16'hA001 emerge in order; stall_cnt counts the held cycles exactly.
- Flush race: both entries valid (16'hB000, 16'hB001), i_valid=1 with 16'hB002, flush=1 for one cycle -> o_ready=0 that cycle. Next cycle o_valid=0, o_data=16'h0800; flush_cnt=1; 16'hB002 is never output.
- SKID=0 build: i_ready=0 with main holding 16'hC000 -> o_ready=0 combinationally. i_ready=1 with i_valid=1 and 16'hC001 -> same-cycle accept; o_data=16'hC001 next cycle.
- Saturation: CNT_WIDTH=4, hold o_valid=0 for 20 cycles -> bubble_cnt=4'hF and stays there; err remains 0 throughout all scenarios.
